usb_rcv_ctrl: RTL and testbench

Receive control unit for the USB full-speed receiver. It sequences the receive datapath: it watches line edges, the end-of-packet detector output, the bit-sample strobe and the byte-complete strobe. It checks the SYNC byte, issues one FIFO write per received data byte, enforces a maximum packet length and flags packet errors. It sits between the line front end (edge detector, eop_detect, bit timer, shift register) and the receive FIFO.

---
 rtl/usb_rcv_ctrl.sv | 134 +++++++++++++
 tb/tb_usb_rcv_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rcv_ctrl.sv
// usb_rcv_ctrl -- receive control FSM for the USB full-speed receiver.
//
// Sequences the receive datapath: waits for a line edge, checks the SYNC
// byte, issues one FIFO write per received data byte, limits the packet to
// MAX_BYTES data bytes and flags packet errors until the next packet starts.
//
// Ports:
//   clk           in   system clock, rising-edge active
//   rst           in   asynchronous active-high reset
//   d_edge        in   one-cycle pulse on any decoded line transition
//   eop           in   level, high while D+ and D- are both low
//   shift_enable  in   one-cycle bit-sample strobe
//   byte_received in   one-cycle pulse after the 8th sampled bit of a byte
//   rcv_data      in   parallel contents of the receive shift register
//   rcving        out  packet in progress
//   w_enable      out  one-cycle FIFO write strobe for rcv_data
//   r_error       out  packet error, held until the next packet starts
//   clr_timer     out  one-cycle clear for the bit timer
//   byte_count    out  data bytes written in the current packet
module usb_rcv_ctrl #(
    parameter logic [7:0] SYNC_BYTE = 8'h80,
    parameter int         MAX_BYTES = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             d_edge,
    input  logic                             eop,
    input  logic                             shift_enable,
    input  logic                             byte_received,
    input  logic [7:0]                       rcv_data,
    output logic                             rcving,
    output logic                             w_enable,
    output logic                             r_error,
    output logic                             clr_timer,
    output logic [$clog2(MAX_BYTES+1)-1:0]   byte_count
);

    localparam int BCW = $clog2(MAX_BYTES + 1);
    localparam logic [BCW-1:0] MAX_CNT = BCW'(MAX_BYTES);

    localparam logic [3:0] S_IDLE              = 4'd0;
    localparam logic [3:0] S_START             = 4'd1;
    localparam logic [3:0] S_SYNC_WAIT         = 4'd2;
    localparam logic [3:0] S_SYNC_CHK          = 4'd3;
    localparam logic [3:0] S_RCV               = 4'd4;
    localparam logic [3:0] S_WRITE             = 4'd5;
    localparam logic [3:0] S_BYTE_END          = 4'd6;
    localparam logic [3:0] S_EOP_WAIT_EDGE     = 4'd7;
    localparam logic [3:0] S_ERR_EOP_WAIT      = 4'd8;
    localparam logic [3:0] S_ERR_EOP_WAIT_EDGE = 4'd9;
    localparam logic [3:0] S_ERR_IDLE          = 4'd10;

    logic [3:0]     state_q, state_d;
    logic [BCW-1:0] count_q, count_d;
    logic           eop_strobe;

    // EOP is only acted on at a bit-sample point, so a glitchy SE0 between
    // samples cannot end the packet.
    assign eop_strobe = eop && shift_enable;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:              if (d_edge) state_d = S_START;
            S_START:             state_d = S_SYNC_WAIT;
            S_SYNC_WAIT: begin
                if (eop_strobe)         state_d = S_ERR_EOP_WAIT_EDGE;
                else if (byte_received) state_d = S_SYNC_CHK;
            end
            S_SYNC_CHK: begin
                if (rcv_data == SYNC_BYTE) state_d = S_RCV;
                else                       state_d = S_ERR_EOP_WAIT;
            end
            S_RCV: begin
                // A full byte with the counter already at the limit is an
                // overlength packet; it is dropped rather than written.
                if (eop_strobe)                                state_d = S_ERR_EOP_WAIT_EDGE;
                else if (byte_received && count_q == MAX_CNT) state_d = S_ERR_EOP_WAIT;
                else if (byte_received)                        state_d = S_WRITE;
            end
            S_WRITE:             state_d = S_BYTE_END;
            S_BYTE_END: begin
                if (eop_strobe)                 state_d = S_EOP_WAIT_EDGE;
                else if (shift_enable && !eop)  state_d = S_RCV;
            end
            S_EOP_WAIT_EDGE:     if (d_edge) state_d = S_IDLE;
            S_ERR_EOP_WAIT:      if (eop_strobe) state_d = S_ERR_EOP_WAIT_EDGE;
            S_ERR_EOP_WAIT_EDGE: if (d_edge) state_d = S_ERR_IDLE;
            S_ERR_IDLE:          if (d_edge) state_d = S_START;
            default:             state_d = S_IDLE;
        endcase
    end

    // Counter clears while in START and advances once per WRITE; the
    // saturation guard keeps it from wrapping even though RCV never enters
    // WRITE at the limit.
    always_comb begin
        count_d = count_q;
        if (state_q == S_START)
            count_d = '0;
        else if (state_q == S_WRITE && count_q != MAX_CNT)
            count_d = count_q + BCW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Moore outputs, decoded from registered state only.
    always_comb begin
        rcving    = 1'b0;
        w_enable  = 1'b0;
        r_error   = 1'b0;
        clr_timer = 1'b0;
        case (state_q)
            S_IDLE:              ;
            S_START:             begin rcving = 1'b1; clr_timer = 1'b1; end
            S_WRITE:             begin rcving = 1'b1; w_enable = 1'b1; end
            S_ERR_EOP_WAIT,
            S_ERR_EOP_WAIT_EDGE: begin rcving = 1'b1; r_error = 1'b1; end
            S_ERR_IDLE:          r_error = 1'b1;
            default:             rcving = 1'b1;
        endcase
    end

    assign byte_count = count_q;

endmodule

// File: tb/tb_usb_rcv_ctrl.sv
// Self-checking bench for usb_rcv_ctrl (built with MAX_BYTES=4).
// Expected FIFO writes are queued as bytes are driven and compared against
// rcv_data whenever w_enable is seen on the falling edge.
module tb_usb_rcv_ctrl;

    localparam int MAXB = 4;
    localparam int BCW  = $clog2(MAXB + 1);

    logic           clk = 1'b0;
    logic           rst;
    logic           d_edge, eop, shift_enable, byte_received;
    logic [7:0]     rcv_data;
    logic           rcving, w_enable, r_error, clr_timer;
    logic [BCW-1:0] byte_count;

    int n_cmp = 0;
    int n_err = 0;
    int n_wr  = 0;
    int wr_base;
    logic [7:0] exp_q[$];

    usb_rcv_ctrl #(.SYNC_BYTE(8'h80), .MAX_BYTES(MAXB)) dut (
        .clk(clk), .rst(rst), .d_edge(d_edge), .eop(eop),
        .shift_enable(shift_enable), .byte_received(byte_received),
        .rcv_data(rcv_data), .rcving(rcving), .w_enable(w_enable),
        .r_error(r_error), .clr_timer(clr_timer), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Write monitor: every w_enable must match the oldest queued byte.
    always @(negedge clk) begin
        if (w_enable) begin
            n_wr++;
            if (exp_q.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
            else                   chk("wr_data", {24'd0, rcv_data}, {24'd0, exp_q.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_edge();
        d_edge = 1'b1;
        tick();
        d_edge = 1'b0;
    endtask

    task automatic bit_strobe();
        shift_enable = 1'b1;
        tick();
        shift_enable = 1'b0;
        repeat (3) tick();
    endtask

    // Eight bit strobes, then byte_received; returns in the cycle just after
    // the byte_received edge.
    task automatic send_bits(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            shift_enable = 1'b1;
            if (i == 7) rcv_data = b;
            tick();
            shift_enable = 1'b0;
            if (i < 7) repeat (3) tick();
        end
        byte_received = 1'b1;
        tick();
        byte_received = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b);
        repeat (3) tick();
    endtask

    // Two-bit SE0 sampled twice, then J; the caller pulses d_edge.
    task automatic send_eop();
        eop = 1'b1;
        bit_strobe();
        bit_strobe();
        eop = 1'b0;
    endtask

    task automatic start_pkt();
        pulse_edge();
        chk("start_clr_timer", clr_timer, 1);
        chk("start_rcving", rcving, 1);
        chk("start_r_error", r_error, 0);
        tick();
        chk("clr_timer_one_cycle", clr_timer, 0);
    endtask

    initial begin
        rst = 1'b1; d_edge = 0; eop = 0; shift_enable = 0; byte_received = 0;
        rcv_data = 8'h00;
        tick(); tick();
        chk("rst_rcving", rcving, 0);
        chk("rst_w_enable", w_enable, 0);
        chk("rst_r_error", r_error, 0);
        chk("rst_clr_timer", clr_timer, 0);
        chk("rst_byte_count", byte_count, 0);
        rst = 1'b0;
        repeat (2) tick();

        // Valid packet
        wr_base = n_wr;
        start_pkt();
        send_byte(8'h80);
        exp_q.push_back(8'hA5); send_byte(8'hA5);
        exp_q.push_back(8'h3C); send_byte(8'h3C);
        send_eop();
        chk("valid_rcving_eop", rcving, 1);
        pulse_edge();
        chk("valid_rcving_end", rcving, 0);
        chk("valid_r_error", r_error, 0);
        chk("valid_byte_count", byte_count, 2);
        chk("valid_writes", n_wr - wr_base, 2);
        chk("valid_queue_empty", exp_q.size(), 0);

        // Bad SYNC
        wr_base = n_wr;
        start_pkt();
        send_byte(8'h81);
        chk("badsync_r_error", r_error, 1);
        send_byte(8'h11);
        send_eop();
        pulse_edge();
        chk("badsync_idle_rcving", rcving, 0);
        chk("badsync_idle_r_error", r_error, 1);
        chk("badsync_writes", n_wr - wr_base, 0);

        // EOP mid-byte (START also clears the held error)
        wr_base = n_wr;
        start_pkt();
        send_byte(8'h80);
        exp_q.push_back(8'h5A); send_byte(8'h5A);
        repeat (3) bit_strobe();
        eop = 1'b1; shift_enable = 1'b1;
        tick();
        shift_enable = 1'b0;
        chk("midbyte_r_error", r_error, 1);
        chk("midbyte_rcving", rcving, 1);
        tick(); eop = 1'b0; tick();
        pulse_edge();
        chk("midbyte_end_rcving", rcving, 0);
        chk("midbyte_end_r_error", r_error, 1);
        chk("midbyte_byte_count", byte_count, 1);
        chk("midbyte_writes", n_wr - wr_base, 1);

        // EOP strobe and byte_received together in RCV
        wr_base = n_wr;
        start_pkt();
        send_byte(8'h80);
        exp_q.push_back(8'h01); send_byte(8'h01);
        repeat (2) bit_strobe();
        eop = 1'b1; shift_enable = 1'b1; byte_received = 1'b1; rcv_data = 8'hEE;
        tick();
        shift_enable = 1'b0; byte_received = 1'b0;
        chk("simul_r_error", r_error, 1);
        repeat (3) tick();
        eop = 1'b0;
        tick();
        chk("simul_writes", n_wr - wr_base, 1);
        chk("simul_byte_count", byte_count, 1);
        pulse_edge();
        chk("simul_end_rcving", rcving, 0);

        // Overlength: MAXB data bytes accepted, the next one is an error
        wr_base = n_wr;
        start_pkt();
        send_byte(8'h80);
        for (int i = 1; i <= MAXB; i++) begin
            exp_q.push_back(8'(i * 16));
            send_byte(8'(i * 16));
        end
        chk("over_count_at_max", byte_count, MAXB);
        chk("over_no_error_yet", r_error, 0);
        send_byte(8'h50);
        chk("over_r_error", r_error, 1);
        chk("over_byte_count", byte_count, MAXB);
        chk("over_writes", n_wr - wr_base, MAXB);
        send_eop();
        pulse_edge();
        chk("over_end_count", byte_count, MAXB);
        chk("over_end_rcving", rcving, 0);

        // Reset during the second WRITE of a packet
        wr_base = n_wr;
        start_pkt();
        send_byte(8'h80);
        exp_q.push_back(8'hA5); send_byte(8'hA5);
        send_bits(8'hC3);
        chk("rstmid_in_write", w_enable, 1);
        chk("rstmid_count_before", byte_count, 1);
        rst = 1'b1;
        #1;
        chk("rstmid_w_enable", w_enable, 0);
        chk("rstmid_rcving", rcving, 0);
        chk("rstmid_byte_count", byte_count, 0);
        chk("rstmid_r_error", r_error, 0);
        chk("rstmid_clr_timer", clr_timer, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("rstmid_writes", n_wr - wr_base, 1);

        // Clean packet after the reset
        wr_base = n_wr;
        start_pkt();
        send_byte(8'h80);
        exp_q.push_back(8'h77); send_byte(8'h77);
        exp_q.push_back(8'h88); send_byte(8'h88);
        send_eop();
        pulse_edge();
        chk("post_rcving", rcving, 0);
        chk("post_r_error", r_error, 0);
        chk("post_byte_count", byte_count, 2);
        chk("post_writes", n_wr - wr_base, 2);
        chk("post_queue_empty", exp_q.size(), 0);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
